// File: rtl/button_param_adjust_pkg.sv
// Shared definitions for the button set-point adjuster.
// Holds the FSM state encoding (so the bench can decode the state) and a
// small helper used to size the step timer.
package button_param_adjust_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;
  localparam logic [1:0] S_LOCK   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_HOLD   = S_HOLD,
    ST_REPEAT = S_REPEAT,
    ST_LOCK   = S_LOCK
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_param_adjust_step_timer.sv
// Hold / auto-repeat interval timer.
// Ports:
//   i_clk, i_reset  : clock, asynchronous active-low reset
//   clear           : restart counting from zero (wins over enable)
//   enable          : advance the counter by one
//   sel_repeat      : 0 = hold interval, 1 = repeat interval
//   term_cnt        : registered, high while the count equals limit-1
module button_param_adjust_step_timer
  import button_param_adjust_pkg::*;
#(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  input  logic sel_repeat,
  output logic term_cnt
);

  localparam int CW = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));

  // Terminal count is registered one increment early: when the current
  // count is limit-2, the incremented count becomes limit-1.
  localparam logic [CW-1:0] HOLD_PRE   = CW'(HOLD_CYCLES - 2);
  localparam logic [CW-1:0] REPEAT_PRE = CW'(REPEAT_CYCLES - 2);

  logic [CW-1:0] cnt_q;
  logic          tc_q;
  logic [CW-1:0] pre_lim;

  assign pre_lim  = sel_repeat ? REPEAT_PRE : HOLD_PRE;
  assign term_cnt = tc_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
      tc_q  <= (cnt_q == pre_lim);
    end
  end

endmodule

// File: rtl/button_param_adjust.sv
// Push-button set-point adjuster: turns debounced active-low up/down button
// levels into a saturated set-point with single-step, hold-delay and
// auto-repeat behaviour. Pressing both buttons locks out stepping until
// both are released.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-low reset
//   i_up, i_down   : debounced buttons, 0 = pressed
//   o_value        : current set-point (reset INIT)
//   o_update       : one-cycle pulse when o_value changes
//   o_at_limit     : registered, high while o_value is MIN or MAX
//
// state  | meaning
// IDLE   | no button held, waiting for a press
// HOLD   | one button held, waiting hold delay before first repeat
// REPEAT | one button held, stepping every repeat interval
// LOCK   | both buttons seen, waiting until both are released
module button_param_adjust
  import button_param_adjust_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int INIT          = 1000,
  parameter int MIN           = 0,
  parameter int MAX           = 4000,
  parameter int STEP          = 10,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_up,
  input  logic             i_down,
  output logic [WIDTH-1:0] o_value,
  output logic             o_update,
  output logic             o_at_limit
);

  localparam logic [WIDTH:0]   MIN_E       = (WIDTH+1)'(MIN);
  localparam logic [WIDTH:0]   MAX_E       = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   STEP_E      = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] INIT_V      = WIDTH'(INIT);
  localparam logic             AT_LIM_INIT = (INIT == MIN) || (INIT == MAX);

  state_e           state_q, state_d;
  logic             dir_up_q, dir_up_d;
  logic [WIDTH-1:0] value_q;
  logic             update_q;
  logic             at_limit_q;

  logic up_p, dn_p, active_p;
  logic step_fire, step_up;
  logic tmr_clear, tmr_enable, tmr_tc;

  logic [WIDTH:0]   val_ext, new_ext;
  logic [WIDTH-1:0] new_val, value_d;

  assign up_p     = ~i_up;
  assign dn_p     = ~i_down;
  assign active_p = dir_up_q ? up_p : dn_p;

  button_param_adjust_step_timer #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_step_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .clear      (tmr_clear),
    .enable     (tmr_enable),
    .sel_repeat (state_q == ST_REPEAT),
    .term_cnt   (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    dir_up_d   = dir_up_q;
    step_fire  = 1'b0;
    step_up    = dir_up_q;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (up_p && dn_p) begin
          state_d = ST_LOCK;
        end else if (up_p || dn_p) begin
          dir_up_d  = up_p;
          step_up   = up_p;
          step_fire = 1'b1;
          tmr_clear = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (up_p && dn_p) begin
          state_d = ST_LOCK;
        end else if (!active_p) begin
          state_d = ST_IDLE;
        end else if (tmr_tc) begin
          step_fire = 1'b1;
          tmr_clear = 1'b1;
          state_d   = ST_REPEAT;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      ST_LOCK: begin
        if (!up_p && !dn_p) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating step, one extra bit so neither sum nor difference wraps.
  always_comb begin
    val_ext = {1'b0, value_q};
    if (step_up) begin
      if (val_ext > (MAX_E - STEP_E)) new_ext = MAX_E;
      else                            new_ext = val_ext + STEP_E;
    end else begin
      if (val_ext < (MIN_E + STEP_E)) new_ext = MIN_E;
      else                            new_ext = val_ext - STEP_E;
    end
    new_val = new_ext[WIDTH-1:0];
    value_d = step_fire ? new_val : value_q;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      dir_up_q   <= 1'b0;
      value_q    <= INIT_V;
      update_q   <= 1'b0;
      at_limit_q <= AT_LIM_INIT;
    end else begin
      state_q    <= state_d;
      dir_up_q   <= dir_up_d;
      value_q    <= value_d;
      update_q   <= step_fire && (new_val != value_q);
      at_limit_q <= (value_d == MIN_E[WIDTH-1:0]) || (value_d == MAX_E[WIDTH-1:0]);
    end
  end

  assign o_value    = value_q;
  assign o_update   = update_q;
  assign o_at_limit = at_limit_q;

endmodule
